// File: rtl/mult_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_ctrl_pkg
// Brief    : Shared types and defaults for the MULT/MULTU HI/LO control stage.
// Revision : 1.0 - initial release
// ============================================================================
package mult_ctrl_pkg;

    localparam int unsigned C_W       = 16;
    localparam int unsigned C_PW      = 2 * C_W;
    localparam int unsigned C_TIMEOUT = 64;
    localparam int unsigned C_CNT_W   = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mult_sign_adj.sv
`default_nettype none
// ============================================================================
// Module   : mult_sign_adj
// Brief    : Per-lane conditional two's-complement negation (magnitude/sign fix).
// Revision : 1.0 - initial release
// ============================================================================
module mult_sign_adj #(
    parameter int W     = 16,
    parameter int LANES = 1
) (
    input  logic [LANES-1:0]   neg,
    input  logic [LANES*W-1:0] din,
    output logic [LANES*W-1:0] dout
);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Negating the most negative value wraps to itself, which read as
        // unsigned is exactly its magnitude.
        assign dout[i*W +: W] = neg[i] ? -din[i*W +: W] : din[i*W +: W];
    end

endmodule
`default_nettype wire

// File: rtl/mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_hilo_ctrl
// Brief    : MULT/MULTU control in front of the shift-add multiplier; drives
//            St, waits for Done, sign-corrects Produto and owns HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mult_hilo_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int W       = C_W,
    parameter int TIMEOUT = C_TIMEOUT,
    parameter int CNT_W   = C_CNT_W
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Req,
    input  logic            Signed_op,
    input  logic [W-1:0]    Op_a,
    input  logic [W-1:0]    Op_b,
    input  logic            Wr_hi,
    input  logic            Wr_lo,
    input  logic [31:0]     Wr_data,
    output logic            Busy,
    output logic            Done_o,
    output logic            Timeout,
    output logic [31:0]     Hi,
    output logic [31:0]     Lo,
    output logic            Mul_st,
    output logic [W-1:0]    Mul_a,
    output logic [W-1:0]    Mul_b,
    input  logic            Mul_idle,
    input  logic            Mul_done,
    input  logic [2*W-1:0]  Mul_produto
);

    localparam int PW = 2 * W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_signed;
    logic               r_started;

    logic               w_accept;
    logic               w_qual_done;
    logic               w_cnt_last;
    logic [W-1:0]       w_mag_a;
    logic [W-1:0]       w_mag_b;
    logic [PW-1:0]      w_prod;
    logic               w_ext;
    logic [31:0]        w_lo_new;

    assign w_accept    = (r_state == IDLE) & Req & Mul_idle;
    // A Done still held from the previous operation must not complete this one.
    assign w_qual_done = Mul_done & (r_started | ~Mul_idle);
    assign w_cnt_last  = (r_cnt == CNT_W'(TIMEOUT - 1));

    mult_sign_adj #(.W(W), .LANES(2)) u_opnd_adj (
        .neg  ({Signed_op & Op_b[W-1], Signed_op & Op_a[W-1]}),
        .din  ({Op_b, Op_a}),
        .dout ({w_mag_b, w_mag_a})
    );

    mult_sign_adj #(.W(PW), .LANES(1)) u_prod_adj (
        .neg  (r_neg),
        .din  (Mul_produto),
        .dout (w_prod)
    );

    assign w_ext = r_signed & w_prod[PW-1];

    // Operand widths up to 16 bits give a product no wider than LO.
    if (PW == 32) begin : g_lo_full
        assign w_lo_new = w_prod;
    end else begin : g_lo_ext
        assign w_lo_new = {{(32-PW){w_ext}}, w_prod};
    end

    always_comb begin
        w_state_nxt = r_state;
        Mul_st      = 1'b0;
        Done_o      = 1'b0;
        case (r_state)
            IDLE:  if (w_accept) w_state_nxt = ISSUE;
            ISSUE: begin
                Mul_st      = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_qual_done)     w_state_nxt = FIN;
                else if (w_cnt_last) w_state_nxt = IDLE;
            end
            FIN: begin
                Done_o      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign Busy = (r_state != IDLE) | (Req & ~Mul_idle);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            r_signed  <= 1'b0;
            r_started <= 1'b0;
            Mul_a     <= '0;
            Mul_b     <= '0;
            Hi        <= '0;
            Lo        <= '0;
            Timeout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    // Moves to HI/LO only land while the pipeline is not stalled.
                    if (Wr_hi) Hi <= Wr_data;
                    if (Wr_lo) Lo <= Wr_data;
                    if (w_accept) begin
                        Mul_a    <= w_mag_a;
                        Mul_b    <= w_mag_b;
                        r_neg    <= Signed_op & (Op_a[W-1] ^ Op_b[W-1]);
                        r_signed <= Signed_op;
                        Timeout  <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_cnt     <= '0;
                    r_started <= 1'b0;
                end
                WAIT: begin
                    if (!Mul_idle) r_started <= 1'b1;
                    if (w_qual_done) begin
                        Hi <= {32{w_ext}};
                        Lo <= w_lo_new;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_cnt_last) Timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_hilo_ctrl
// Brief    : Self-checking bench for mult_hilo_ctrl with a 34-cycle multiplier.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_ctrl;

    localparam int LAT = 34;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Req = 1'b0;
    logic        Signed_op = 1'b0;
    logic [15:0] Op_a = '0;
    logic [15:0] Op_b = '0;
    logic        Wr_hi = 1'b0;
    logic        Wr_lo = 1'b0;
    logic [31:0] Wr_data = '0;
    logic        Busy, Done_o, Timeout, Mul_st;
    logic [31:0] Hi, Lo;
    logic [15:0] Mul_a, Mul_b;
    logic        Mul_idle = 1'b1;
    logic        Mul_done = 1'b0;
    logic [31:0] Mul_produto = '0;

    always #5 Clk = ~Clk;

    mult_hilo_ctrl #(.W(16), .TIMEOUT(64), .CNT_W(7)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Signed_op(Signed_op),
        .Op_a(Op_a), .Op_b(Op_b), .Wr_hi(Wr_hi), .Wr_lo(Wr_lo),
        .Wr_data(Wr_data), .Busy(Busy), .Done_o(Done_o), .Timeout(Timeout),
        .Hi(Hi), .Lo(Lo), .Mul_st(Mul_st), .Mul_a(Mul_a), .Mul_b(Mul_b),
        .Mul_idle(Mul_idle), .Mul_done(Mul_done), .Mul_produto(Mul_produto)
    );

    // Behavioural multiplier: Idle low while computing, Done held until next St.
    logic [15:0] m_a = '0, m_b = '0;
    int          m_cnt = 0;
    bit          m_hang = 1'b0;
    always @(posedge Clk) begin
        if (Mul_st) begin
            m_cnt    <= LAT;
            m_a      <= Mul_a;
            m_b      <= Mul_b;
            Mul_idle <= 1'b0;
            Mul_done <= 1'b0;
        end else if (m_cnt != 0 && !m_hang) begin
            if (m_cnt == 1) begin
                Mul_idle    <= 1'b1;
                Mul_done    <= 1'b1;
                Mul_produto <= 32'(m_a) * 32'(m_b);
            end
            m_cnt <= m_cnt - 1;
        end
    end

    typedef struct packed {
        logic        s;
        logic [15:0] a, b, ea, eb;
        logic [31:0] ehi, elo;
    } vec_t;

    vec_t sb_q[$];
    vec_t mon_v;
    vec_t vecs[8];
    int   checks = 0, failures = 0, st_count = 0, done_count = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard consumer: operand check at St, HI/LO check at Done_o.
    always @(negedge Clk) begin
        if (Reset) begin
            if (Mul_st) begin
                st_count++;
                if (sb_q.size() == 0) check32("st_without_request", 32'(sb_q.size()), 32'd1);
                else begin
                    check32("mul_a", 32'(Mul_a), 32'(sb_q[0].ea));
                    check32("mul_b", 32'(Mul_b), 32'(sb_q[0].eb));
                end
            end
            if (Done_o) begin
                done_count++;
                if (sb_q.size() == 0) check32("done_without_request", 32'(sb_q.size()), 32'd1);
                else begin
                    mon_v = sb_q.pop_front();
                    check32("hi", Hi, mon_v.ehi);
                    check32("lo", Lo, mon_v.elo);
                end
            end
        end
    end

    task automatic start_op(input vec_t v, input bit hold);
        bit ok;
        sb_q.push_back(v);
        Signed_op = v.s;
        Op_a = v.a;
        Op_b = v.b;
        Req = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (Mul_st) begin ok = 1'b1; break; end
        end
        if (!hold) Req = 1'b0;
        if (!ok) bound_fail("accept");
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (Busy && n < 300) begin
            n++;
            tick();
        end
        if (Busy) bound_fail("busy_release");
    endtask

    function automatic vec_t mk(input logic s, input logic [15:0] a, b, ea, eb,
                                input logic [31:0] ehi, elo);
        vec_t v;
        v.s = s; v.a = a; v.b = b; v.ea = ea; v.eb = eb; v.ehi = ehi; v.elo = elo;
        return v;
    endfunction

    initial begin
        int n, st0, dc;
        vecs[0] = mk(1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 32'h0,        32'hFFFE0001);
        vecs[1] = mk(1'b1, 16'hFFFD, 16'h0005, 16'h0003, 16'h0005, 32'hFFFFFFFF, 32'hFFFFFFF1);
        vecs[2] = mk(1'b1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 32'h0,        32'h40000000);
        vecs[3] = mk(1'b1, 16'hFFFD, 16'h0000, 16'h0003, 16'h0000, 32'h0,        32'h0);
        vecs[4] = mk(1'b1, 16'h0007, 16'hFFF9, 16'h0007, 16'h0007, 32'hFFFFFFFF, 32'hFFFFFFCF);
        vecs[5] = mk(1'b0, 16'h8000, 16'h0002, 16'h8000, 16'h0002, 32'h0,        32'h00010000);
        vecs[6] = mk(1'b1, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 32'hFFFFFFFF, 32'hC0008000);
        vecs[7] = mk(1'b1, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0001, 32'h0,        32'h00000001);

        repeat (2) @(posedge Clk);
        #1;
        check32("rst_hi", Hi, 32'h0);
        check32("rst_lo", Lo, 32'h0);
        check32("rst_busy", 32'(Busy), 32'h0);
        check32("rst_st", 32'(Mul_st), 32'h0);
        check32("rst_done", 32'(Done_o), 32'h0);
        check32("rst_timeout", 32'(Timeout), 32'h0);
        Reset = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            st0 = st_count;
            start_op(vecs[i], 1'b0);
            wait_idle(n);
            check32("busy_cycles", 32'(n), 32'(LAT + 3));
            check32("st_pulses", 32'(st_count - st0), 32'd1);
        end

        // Back-to-back: Req held through FIN, second op 3 x 0 must see no stale Done.
        start_op(vecs[2], 1'b1);
        sb_q.push_back(mk(1'b1, 16'h0003, 16'h0000, 16'h0003, 16'h0000, 32'h0, 32'h0));
        Op_a = 16'h0003;
        Op_b = 16'h0000;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            n++;
            if (n == 37) check32("b2b_busy_gap", 32'(Busy), 32'h0);
            if (Mul_st) break;
        end
        check32("b2b_st_spacing", 32'(n), 32'd38);
        Req = 1'b0;
        wait_idle(n);
        check32("b2b_busy_cycles", 32'(n), 32'(LAT + 3));

        // MTHI in IDLE, then MTLO together with a request, then MTHI during WAIT.
        Wr_hi = 1'b1;
        Wr_data = 32'hA5A5A5A5;
        tick();
        Wr_hi = 1'b0;
        check32("mthi_idle", Hi, 32'hA5A5A5A5);
        Wr_lo = 1'b1;
        Wr_data = 32'h12345678;
        start_op(mk(1'b0, 16'h0002, 16'h0003, 16'h0002, 16'h0003, 32'h0, 32'h6), 1'b0);
        Wr_lo = 1'b0;
        check32("mtlo_with_req", Lo, 32'h12345678);
        repeat (5) tick();
        Wr_hi = 1'b1;
        Wr_data = 32'hDEADBEEF;
        tick();
        Wr_hi = 1'b0;
        check32("mthi_wait_dropped", Hi, 32'hA5A5A5A5);
        wait_idle(n);

        // Watchdog: the multiplier never finishes.
        Wr_hi = 1'b1;
        Wr_data = 32'h0BADF00D;
        tick();
        Wr_hi = 1'b0;
        m_hang = 1'b1;
        start_op(mk(1'b0, 16'h0004, 16'h0005, 16'h0004, 16'h0005, 32'h0, 32'h14), 1'b0);
        wait_idle(n);
        check32("wd_busy_cycles", 32'(n), 32'd65);
        check32("wd_timeout", 32'(Timeout), 32'h1);
        check32("wd_hi_kept", Hi, 32'h0BADF00D);
        check32("wd_lo_kept", Lo, 32'h6);
        void'(sb_q.pop_front());
        m_hang = 1'b0;
        n = 0;
        while (!Mul_idle && n < 100) begin n++; tick(); end
        if (!Mul_idle) bound_fail("wd_model_idle");
        tick();
        check32("wd_timeout_sticky", 32'(Timeout), 32'h1);
        start_op(mk(1'b0, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 32'h0, 32'h00010000), 1'b0);
        check32("wd_timeout_cleared", 32'(Timeout), 32'h0);
        wait_idle(n);

        // Asynchronous reset in WAIT; the late Done must be ignored.
        start_op(mk(1'b0, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 32'h0, 32'h0000FE01), 1'b0);
        repeat (5) tick();
        Reset = 1'b0;
        #2;
        check32("arst_hi", Hi, 32'h0);
        check32("arst_lo", Lo, 32'h0);
        check32("arst_busy", 32'(Busy), 32'h0);
        check32("arst_st", 32'(Mul_st), 32'h0);
        check32("arst_mul_a", 32'(Mul_a), 32'h0);
        void'(sb_q.pop_front());
        tick();
        Reset = 1'b1;
        dc = done_count;
        n = 0;
        while (!Mul_done && n < 100) begin n++; tick(); end
        if (!Mul_done) bound_fail("arst_model_done");
        repeat (3) tick();
        check32("arst_no_done", 32'(done_count - dc), 32'h0);
        check32("arst_busy_after", 32'(Busy), 32'h0);
        check32("arst_lo_after", Lo, 32'h0);

        check32("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
